uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side byte buffer directly downstream of the UART receiver. Captures each received byte on the receiver's done indication and holds it in a circular FIFO. Presents bytes to the host or parser through a valid/ready handshake. Reports fill level, full/empty and a sticky overflow flag.

Parameters:
DEPTH, 16, number of byte entries; power of two, minimum 2
AW, 4, pointer width = log2(DEPTH)
WATERMARK, 12, almost-full threshold in entries; used only with UART_RX_FIFO_WATERMARK_EN

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_rx_done  in  1  receiver done level; high for one or more clk cycles per byte
i_rx_data  in  8  received byte; valid whenever i_rx_done is high
o_valid  out  1  head entry available (equals not empty)
o_data  out  8  head byte; meaningful only while o_valid = 1
i_ready  in  1  consumer accepts head byte this cycle when o_valid = 1
o_count  out  AW+1  current occupancy, 0..DEPTH
o_full  out  1  count == DEPTH
o_empty  out  1  count == 0
o_overflow  out  1  sticky: a byte was dropped because the FIFO was full
i_clr_ovf  in  1  one-cycle clear of o_overflow
o_almost_full  out  1  count >= WATERMARK (feature-dependent)

Behaviour:
- Reset, applied synchronously on a clk edge with reset = 1:
  - wr_ptr, rd_ptr and count = 0
  - o_valid = 0, o_empty = 1, o_full = 0, o_overflow = 0, o_almost_full = 0
  - Edge-detect register = 1, so a done level already high at reset release is not captured.
  - Storage contents are not reset. o_data is don't-care while o_valid = 0.
  - Reset mid-operation discards all buffered bytes immediately.
- Write strobe:
  - wr_req = i_rx_done & ~rx_done_q, where rx_done_q is i_rx_done delayed by one clk.
  - Exactly one write per done level, however long the level lasts.
  - i_rx_data is sampled in the same cycle as the rising edge.
- Read: rd_fire = o_valid & i_ready.
  - o_data = mem[rd_ptr], show-ahead and combinational from storage.
  - On rd_fire, rd_ptr advances on the next edge.
- Write accepted when wr_req & (~o_full | rd_fire).
  - A write into a full FIFO in the same cycle as a read is accepted.
  - Count stays at DEPTH in that case.
- Write dropped when wr_req & o_full & ~rd_fire.
  - Storage and pointers are unchanged.
  - o_overflow is set on the next edge.
- Count update:
  - +1 on write only, -1 on read only, unchanged on both or neither.
- Latency: a byte written in cycle N gives o_valid = 1 and correct o_data from cycle N+1.
- Write and read in the same cycle while empty: the read is not valid, so there is no read; the write proceeds.
- Pointers wrap modulo DEPTH. Full and empty are derived from count, not from pointer comparison.
- i_ready while o_valid = 0 has no effect.
- Overflow flag:
  - Cleared by i_clr_ovf.
  - If a clear and a new drop happen in the same cycle, set wins and o_overflow = 1.
- All status outputs are registered or derived from registered state; no combinational path from i_ready to o_valid.

Optional Feature:
UART_RX_FIFO_WATERMARK_EN
- Defined: o_almost_full = (count >= WATERMARK), updated on the same edge as count.
- Not defined: o_almost_full tied to 0 and the WATERMARK comparator is not built. Port list is unchanged.

Decomposition:
- Shared package uart_pkg: UART_DATA_W = 8 and default FIFO depth constant, shared with the UART receiver and transmitter.
- One natural sub-module, uart_fifo_mem: DEPTH x 8 register array with synchronous write port and asynchronous read port.
- Pointers, count, edge detect and flags stay in the top level.

Test Plan:
- Reset, then hold i_rx_done high for 20 cycles with i_rx_data = 0xA5, i_ready = 0 -> count = 1, o_valid = 1, o_data = 0xA5 from the cycle after the rising edge. No second write.
- Write 0x01..0x10 as 16 separate done pulses with i_ready = 0 -> o_full = 1, count = 16. A 17th pulse (0x11) gives o_overflow = 1 and count = 16. Draining returns 0x01..0x10 in order.
- Full FIFO, i_ready = 1, and a done edge with 0x77 in the same cycle -> write accepted, count stays 16, 0x77 appears last, o_overflow stays 0.
- Write 40 bytes with i_ready held high -> all 40 are read in order across pointer wrap. count never exceeds 1. o_empty = 1 at the end.
- With o_overflow = 1, pulse i_clr_ovf in the same cycle as a new dropped write -> o_overflow remains 1. Pulse i_clr_ovf alone -> o_overflow = 0.
- With UART_RX_FIFO_WATERMARK_EN and WATERMARK = 12: o_almost_full rises on the edge where count becomes 12 and falls when count drops to 11. Without the macro, o_almost_full stays 0 throughout.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants used by the receiver, transmitter and the byte FIFOs.
package uart_pkg;

    // Width of one UART data character.
    localparam int unsigned UART_DATA_W     = 8;

    // Default byte-FIFO depth used across the UART blocks.
    localparam int unsigned UART_FIFO_DEPTH = 16;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo_if.sv
// Byte stream bundle between the UART receiver, the RX FIFO and its consumer.
// The write side is the receiver's done level plus data.
// The read side is a show-ahead valid/ready handshake.
interface uart_rx_fifo_if;
    import uart_pkg::*;

    logic                   i_rx_done;
    logic [UART_DATA_W-1:0] i_rx_data;
    logic                   o_valid;
    logic [UART_DATA_W-1:0] o_data;
    logic                   i_ready;

    // Driver side: receiver plus consumer.
    modport master (
        output i_rx_done,
        output i_rx_data,
        output i_ready,
        input  o_valid,
        input  o_data
    );

    // FIFO side.
    modport slave (
        input  i_rx_done,
        input  i_rx_data,
        input  i_ready,
        output o_valid,
        output o_data
    );

endinterface : uart_rx_fifo_if

// File: rtl/uart_fifo_mem.sv
// DEPTH x UART_DATA_W register array.
// It has one synchronous write port and one asynchronous read port.
// The read data is show-ahead: it follows i_raddr combinationally.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = UART_FIFO_DEPTH,
    parameter int unsigned AW    = 4
) (
    input  logic                   clk,
    input  logic                   i_we,
    input  logic [AW-1:0]          i_waddr,
    input  logic [UART_DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]          i_raddr,
    output logic [UART_DATA_W-1:0] o_rdata
);

    logic [UART_DATA_W-1:0] r_mem [DEPTH];

    // Store the incoming byte at the write pointer.
    // The contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO that sits directly downstream of the UART receiver.
// It captures one byte per rising edge of the receiver's done level.
// Bytes are presented through a valid/ready handshake.
// It reports the fill level, full/empty, and a sticky overflow flag.
// Optional feature: define UART_RX_FIFO_WATERMARK_EN to build the almost-full
// comparator (count >= WATERMARK). Without it, o_almost_full is tied low.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH     = UART_FIFO_DEPTH,
    parameter int unsigned AW        = 4,
    parameter int unsigned WATERMARK = 12
) (
    input  logic               clk,
    input  logic               reset,
    uart_rx_fifo_if.slave      bus,
    output logic [AW:0]        o_count,
    output logic               o_full,
    output logic               o_empty,
    output logic               o_overflow,
    input  logic               i_clr_ovf,
    output logic               o_almost_full
);

    localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_rx_done_q;
    logic          r_overflow;

    logic          w_wr_req;
    logic          w_rd_fire;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_en;
    logic          w_drop;
    logic [AW:0]   w_count_nxt;

    // Full and empty come from the count, so a full FIFO is never mistaken
    // for an empty one when the pointers are equal.
    assign w_full    = (r_count == COUNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_wr_req  = bus.i_rx_done & ~r_rx_done_q;
    assign w_rd_fire = ~w_empty & bus.i_ready;
    // A read in the same cycle frees a slot, so a write into a full FIFO is
    // still accepted in that case.
    assign w_wr_en   = w_wr_req & (~w_full | w_rd_fire);
    assign w_drop    = w_wr_req & w_full & ~w_rd_fire;

    // Compute the occupancy for the next cycle from the accepted write and read.
    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_wr_en, w_rd_fire})
            2'b10:   w_count_nxt = r_count + COUNT_ONE;
            2'b01:   w_count_nxt = r_count - COUNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Delay the done level to detect its rising edge.
    // The register resets high, so a level that is already high when reset
    // is released is not captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_done_q <= 1'b1;
        end else begin
            r_rx_done_q <= bus.i_rx_done;
        end
    end

    // Update the pointers and the occupancy.
    // Pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
        end
    end

    // Sticky overflow flag. A new drop takes priority over a clear in the
    // same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (i_clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_WATERMARK_EN
    logic r_almost_full;

    // Register the almost-full flag from the next count, so it changes on
    // the same edge as o_count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_count_nxt >= (AW+1)'(WATERMARK));
        end
    end

    assign o_almost_full = r_almost_full;
`else
    assign o_almost_full = 1'b0;
`endif

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.i_rx_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (bus.o_data)
    );

    assign bus.o_valid = ~w_empty;
    assign o_count     = r_count;
    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_overflow  = r_overflow;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Directed scoreboard bench for uart_rx_fifo.
// Expected bytes are queued when a done edge is driven, and checked when
// the FIFO presents them.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned WM    = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW:0]   count;
    logic          full, empty, ovf, clr_ovf, afull;

    int unsigned   total = 0;
    int unsigned   bad   = 0;
    logic [7:0]    sb [$];
    logic [7:0]    exp_b;

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .WATERMARK (WM)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .o_count       (count),
        .o_full        (full),
        .o_empty       (empty),
        .o_overflow    (ovf),
        .i_clr_ovf     (clr_ovf),
        .o_almost_full (afull)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_af(input int unsigned c);
`ifdef UART_RX_FIFO_WATERMARK_EN
        return (c >= WM);
`else
        return 1'b0;
`endif
    endfunction

    // Drive one done pulse: high for one cycle, then low for one cycle.
    task automatic pulse(input logic [7:0] b, input bit expect_accept);
        bus.i_rx_done = 1'b1;
        bus.i_rx_data = b;
        if (expect_accept) sb.push_back(b);
        tick();
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = 8'h00;
        tick();
    endtask

    // Consume the head entry and compare it with the scoreboard.
    task automatic pop_check(input string tag);
        check({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
        exp_b = sb.pop_front();
        check({tag, "_data"}, 32'(bus.o_data), 32'(exp_b));
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        check({tag, "_count"}, 32'(count), 32'(sb.size()));
        check({tag, "_afull"}, 32'(afull), 32'(exp_af(sb.size())));
    endtask

    initial begin
        reset = 1'b1;
        clr_ovf = 1'b0;
        bus.i_rx_done = 1'b1;          // level already high across reset
        bus.i_rx_data = 8'h3C;
        bus.i_ready   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full), 32'd0);
        check("rst_ovf",   32'(ovf), 32'd0);
        check("rst_afull", 32'(afull), 32'd0);
        tick();
        tick();
        check("held_at_release", 32'(count), 32'd0);
        bus.i_rx_done = 1'b0;
        tick();

        // One long done level captures exactly one byte.
        bus.i_rx_done = 1'b1;
        bus.i_rx_data = 8'hA5;
        sb.push_back(8'hA5);
        tick();
        check("long_valid", 32'(bus.o_valid), 32'd1);
        check("long_data",  32'(bus.o_data), 32'hA5);
        for (int i = 0; i < 19; i++) begin
            tick();
            check("long_count", 32'(count), 32'd1);
        end
        bus.i_rx_done = 1'b0;
        tick();
        pop_check("long_pop");
        check("long_empty", 32'(empty), 32'd1);

        // Fill to full, checking occupancy and the watermark on every step.
        for (int i = 1; i <= 16; i++) begin
            pulse(8'(i), 1'b1);
            check("fill_count", 32'(count), 32'(i));
            check("fill_afull", 32'(afull), 32'(exp_af(i)));
        end
        check("full_flag", 32'(full), 32'd1);
        check("full_ovf0", 32'(ovf), 32'd0);
        pulse(8'h11, 1'b0);
        check("drop_ovf",   32'(ovf), 32'd1);
        check("drop_count", 32'(count), 32'd16);

        // A clear and a new drop in the same cycle leave the flag set.
        bus.i_rx_done = 1'b1;
        bus.i_rx_data = 8'h22;
        clr_ovf = 1'b1;
        tick();
        bus.i_rx_done = 1'b0;
        clr_ovf = 1'b0;
        check("clr_vs_drop_ovf", 32'(ovf), 32'd1);
        check("clr_vs_drop_cnt", 32'(count), 32'd16);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_alone_ovf", 32'(ovf), 32'd0);

        // A write into a full FIFO together with a read is accepted.
        check("fullrw_head", 32'(bus.o_data), 32'(sb[0]));
        exp_b = sb.pop_front();
        sb.push_back(8'h77);
        bus.i_ready   = 1'b1;
        bus.i_rx_done = 1'b1;
        bus.i_rx_data = 8'h77;
        tick();
        bus.i_ready   = 1'b0;
        bus.i_rx_done = 1'b0;
        check("fullrw_count", 32'(count), 32'd16);
        check("fullrw_full",  32'(full), 32'd1);
        check("fullrw_ovf",   32'(ovf), 32'd0);
        tick();
        for (int i = 0; i < 16; i++) pop_check("drain");
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_valid", 32'(bus.o_valid), 32'd0);

        // Streaming with ready held high, across several pointer wraps.
        bus.i_ready = 1'b1;
        tick();
        check("ready_on_empty", 32'(count), 32'd0);
        for (int i = 0; i < 40; i++) begin
            bus.i_rx_done = 1'b1;
            bus.i_rx_data = 8'(i * 7 + 3);
            sb.push_back(8'(i * 7 + 3));
            tick();
            bus.i_rx_done = 1'b0;
            check("stream_count1", 32'(count), 32'd1);
            exp_b = sb.pop_front();
            check("stream_data", 32'(bus.o_data), 32'(exp_b));
            tick();
            check("stream_count0", 32'(count), 32'd0);
        end
        bus.i_ready = 1'b0;
        check("stream_empty", 32'(empty), 32'd1);

        // A reset in the middle of operation discards the buffered bytes.
        pulse(8'hE1, 1'b0);
        pulse(8'hE2, 1'b0);
        pulse(8'hE3, 1'b0);
        check("pre_reset_count", 32'(count), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset_count", 32'(count), 32'd0);
        check("mid_reset_valid", 32'(bus.o_valid), 32'd0);
        check("mid_reset_empty", 32'(empty), 32'd1);
        tick();
        pulse(8'h5A, 1'b1);
        pop_check("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule : tb_uart_rx_fifo
